nibble_serial_adder: RTL

- Multi-cycle WIDTH-bit adder built around one 4-bit ripple slice (4 chained full-adder cells) reused once per cycle, least-significant nibble first.
- Sits as the sequencing stage that feeds the 4-bit adder datapath: accepts wide operands over a valid/ready handshake, steps nibbles through the slice with a registered carry, and presents the full sum and carry-out downstream.
- Trades latency (WIDTH/4 cycles) for area versus a full-width ripple adder.

---
 rtl/nibble_serial_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
//------------------------------------------------------------------------------
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder that reuses one 4-bit ripple slice per cycle,
//               LSB nibble first. Optional subtract mode: NIBBLE_SERIAL_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int c_NNIB  = WIDTH / 4;
    localparam int c_CNT_W = (c_NNIB > 1) ? $clog2(c_NNIB) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NNIB - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic [3:0]         w_na;
    logic [3:0]         w_nb;
    logic [3:0]         w_s4;
    logic [4:0]         w_c;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and force a carry-in of one.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_na   = r_a[{r_cnt, 2'b00} +: 4];
    assign w_nb   = r_b[{r_cnt, 2'b00} +: 4];
    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign w_s4[gi]    = w_na[gi] ^ w_nb[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (w_na[gi] & w_nb[gi]) | (w_c[gi] & (w_na[gi] ^ w_nb[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (in_valid)         w_state_next = c_S_RUN;
            c_S_RUN:  if (r_cnt == c_LAST)  w_state_next = c_S_DONE;
            c_S_DONE: if (out_ready)        w_state_next = c_S_IDLE;
            default:                        w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                    end
                end
                c_S_RUN: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_s4;
                    r_carry                    <= w_c[4];
                    if (r_cnt == c_LAST) begin
                        r_cout <= w_c[4];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE);
    assign out_valid = (r_state == c_S_DONE);
    assign busy      = (r_state != c_S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

`default_nettype wire
